line_engine: RTL and testbench



---
 rtl/line_engine.sv | 173 +++++++++++++++++
 tb/tb_line_engine.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_engine.sv
// rtl/line_engine.sv - Bresenham line rasterizer with valid/ready pixel write port
//
// Latches line endpoints and colour from CPU strobes and, on trigger, walks
// the line one pixel per cycle. Each on-screen pixel is emitted as a 32-bit
// frame-buffer write; off-screen pixels are skipped.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   line_color          colour, loaded on line_color_valid
//   line_point          coordinate value for the x0/y0/x1/y1 load strobes
//   line_*_valid        shadow register load strobes
//   line_trigger        start drawing (accepted only while line_ready)
//   line_ready          engine idle
//   px_addr/px_data     pixel write address and colour
//   px_valid/px_ready   pixel write handshake
module line_engine #(
  parameter int          H_RES   = 1024,
  parameter int          V_RES   = 768,
  parameter logic [31:0] FB_BASE = 32'h1080_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] line_color,
  input  logic [9:0]  line_point,
  input  logic        line_color_valid,
  input  logic        line_x0_valid,
  input  logic        line_y0_valid,
  input  logic        line_x1_valid,
  input  logic        line_y1_valid,
  input  logic        line_trigger,
  output logic        line_ready,
  output logic [31:0] px_addr,
  output logic [31:0] px_data,
  output logic        px_valid,
  input  logic        px_ready
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);

  state_t             state_q, state_d;
  logic [9:0]         sh_x0_q, sh_x0_d, sh_y0_q, sh_y0_d;
  logic [9:0]         sh_x1_q, sh_x1_d, sh_y1_q, sh_y1_d;
  logic [31:0]        sh_color_q, sh_color_d;
  logic [9:0]         x_q, x_d, y_q, y_d, x1_q, x1_d, y1_q, y1_d;
  logic [9:0]         dx_q, dx_d, dy_q, dy_d;
  logic               sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [11:0] err_q, err_d;
  logic [31:0]        color_q, color_d;

  logic [9:0]         dx_calc, dy_calc;
  logic signed [12:0] e2, neg_dy, dx_s;
  logic               step_x, step_y, on_screen, at_end;

  // Working x/y hold x0/y0 from the trigger snapshot, so SETUP derives the
  // deltas directly from them.
  assign dx_calc   = (x1_q > x_q) ? (x1_q - x_q) : (x_q - x1_q);
  assign dy_calc   = (y1_q > y_q) ? (y1_q - y_q) : (y_q - y1_q);
  assign e2        = {err_q, 1'b0};
  assign neg_dy    = -$signed({3'b000, dy_q});
  assign dx_s      = $signed({3'b000, dx_q});
  assign step_x    = (e2 >= neg_dy);
  assign step_y    = (e2 <= dx_s);
  assign on_screen = ({1'b0, x_q} < H_LIM) && ({1'b0, y_q} < V_LIM);
  assign at_end    = (x_q == x1_q) && (y_q == y1_q);

  // Outputs decode from state so reset clears them without waiting for a clock.
  assign line_ready = (state_q == S_IDLE);
  assign px_valid   = (state_q == S_DRAW) && on_screen;
  assign px_addr    = px_valid ? (FB_BASE | {10'b0, y_q, x_q, 2'b00}) : 32'd0;
  assign px_data    = px_valid ? color_q : 32'd0;

  always_comb begin
    state_d    = state_q;
    sh_x0_d    = sh_x0_q;
    sh_y0_d    = sh_y0_q;
    sh_x1_d    = sh_x1_q;
    sh_y1_d    = sh_y1_q;
    sh_color_d = sh_color_q;
    x_d        = x_q;
    y_d        = y_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    sx_neg_d   = sx_neg_q;
    sy_neg_d   = sy_neg_q;
    err_d      = err_q;
    color_d    = color_q;

    if (line_x0_valid)    sh_x0_d    = line_point;
    if (line_y0_valid)    sh_y0_d    = line_point;
    if (line_x1_valid)    sh_x1_d    = line_point;
    if (line_y1_valid)    sh_y1_d    = line_point;
    if (line_color_valid) sh_color_d = line_color;

    case (state_q)
      S_IDLE: begin
        if (line_trigger) begin
          x_d     = sh_x0_q;
          y_d     = sh_y0_q;
          x1_d    = sh_x1_q;
          y1_d    = sh_y1_q;
          color_d = sh_color_q;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        dx_d     = dx_calc;
        dy_d     = dy_calc;
        sx_neg_d = !(x_q < x1_q);
        sy_neg_d = !(y_q < y1_q);
        err_d    = $signed({2'b00, dx_calc} - {2'b00, dy_calc});
        state_d  = S_DRAW;
      end
      S_DRAW: begin
        if (!on_screen || px_ready) begin
          if (at_end) begin
            state_d = S_IDLE;
          end else begin
            // Both error adjustments are taken from the pre-update err.
            err_d = err_q - (step_x ? $signed({2'b00, dy_q}) : 12'sd0)
                          + (step_y ? $signed({2'b00, dx_q}) : 12'sd0);
            if (step_x) x_d = sx_neg_q ? (x_q - 10'd1) : (x_q + 10'd1);
            if (step_y) y_d = sy_neg_q ? (y_q - 10'd1) : (y_q + 10'd1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sh_x0_q    <= '0;
      sh_y0_q    <= '0;
      sh_x1_q    <= '0;
      sh_y1_q    <= '0;
      sh_color_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      sx_neg_q   <= 1'b0;
      sy_neg_q   <= 1'b0;
      err_q      <= '0;
      color_q    <= '0;
    end else begin
      state_q    <= state_d;
      sh_x0_q    <= sh_x0_d;
      sh_y0_q    <= sh_y0_d;
      sh_x1_q    <= sh_x1_d;
      sh_y1_q    <= sh_y1_d;
      sh_color_q <= sh_color_d;
      x_q        <= x_d;
      y_q        <= y_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      sx_neg_q   <= sx_neg_d;
      sy_neg_q   <= sy_neg_d;
      err_q      <= err_d;
      color_q    <= color_d;
    end
  end

endmodule

// File: tb/tb_line_engine.sv
// tb/tb_line_engine.sv - scoreboard bench for line_engine
module tb_line_engine;

  localparam logic [31:0] FB_BASE = 32'h1080_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] line_color;
  logic [9:0]  line_point;
  logic        line_color_valid, line_x0_valid, line_y0_valid;
  logic        line_x1_valid, line_y1_valid, line_trigger;
  logic        line_ready;
  logic [31:0] px_addr, px_data;
  logic        px_valid, px_ready;

  line_engine dut (
    .clk              (clk),
    .rst              (rst),
    .line_color       (line_color),
    .line_point       (line_point),
    .line_color_valid (line_color_valid),
    .line_x0_valid    (line_x0_valid),
    .line_y0_valid    (line_y0_valid),
    .line_x1_valid    (line_x1_valid),
    .line_y1_valid    (line_y1_valid),
    .line_trigger     (line_trigger),
    .line_ready       (line_ready),
    .px_addr          (px_addr),
    .px_data          (px_data),
    .px_valid         (px_valid),
    .px_ready         (px_ready)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [63:0] sb[$];
  bit          rnd_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pa(input int x, input int y);
    return FB_BASE | 32'((y << 12) | (x << 2));
  endfunction

  // Reference Bresenham walk; returns the number of DRAW cycles.
  function automatic int model_line(input int x0, input int y0, input int x1, input int y1,
                                    input logic [31:0] col);
    int dx, dy, sx, sy, err, e2, x, y, n;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y1 - y0 : y0 - y1;
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx - dy;
    x = x0;
    y = y0;
    n = 0;
    forever begin
      n++;
      if (x < 1024 && y < 768) sb.push_back({pa(x, y), col});
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= -dy) begin err -= dy; x += sx; end
      if (e2 <= dx)  begin err += dx; y += sy; end
    end
    return n;
  endfunction

  always @(negedge clk) begin
    logic [63:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", px_valid, 1);
        check("hold_addr", px_addr, prev_addr);
        check("hold_data", px_data, prev_data);
      end
      if (px_valid && px_ready) begin
        if (sb.size() == 0) check("px_unexpected", px_addr, 0);
        else begin
          e = sb.pop_front();
          check("px_addr", px_addr, e[63:32]);
          check("px_data", px_data, e[31:0]);
        end
      end
      prev_stall = px_valid && !px_ready;
      prev_addr  = px_addr;
      prev_data  = px_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int sel, input logic [31:0] v);
    line_point = v[9:0];
    line_color = v;
    case (sel)
      0: line_x0_valid = 1'b1;
      1: line_y0_valid = 1'b1;
      2: line_x1_valid = 1'b1;
      3: line_y1_valid = 1'b1;
      default: line_color_valid = 1'b1;
    endcase
    tick();
    {line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid, line_color_valid} = '0;
  endtask

  task automatic load(input int x0, input int y0, input int x1, input int y1,
                      input logic [31:0] col);
    strobe(0, 32'(x0));
    strobe(1, 32'(y0));
    strobe(2, 32'(x1));
    strobe(3, 32'(y1));
    strobe(4, col);
  endtask

  task automatic trigger();
    line_trigger = 1'b1;
    tick();
    line_trigger = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (!line_ready && cycles < 5000) begin
      if (rnd_ready) px_ready = ($urandom_range(0, 3) != 0);
      tick();
      cycles++;
    end
    px_ready = 1'b1;
    if (!line_ready) check("idle_timeout", line_ready, 1);
  endtask

  initial begin
    int c, n;
    int rx0, ry0, rx1, ry1;
    rst = 1'b1;
    line_color = '0;
    line_point = '0;
    {line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid, line_color_valid} = '0;
    line_trigger = 1'b0;
    px_ready = 1'b1;
    #3;
    check("rst_ready", line_ready, 1);
    check("rst_valid", px_valid, 0);
    check("rst_addr", px_addr, 0);
    check("rst_data", px_data, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Horizontal line with latency checks
    load(0, 0, 3, 0, 32'h00FF_0000);
    sb.push_back({32'h1080_0000, 32'h00FF_0000});
    sb.push_back({32'h1080_0004, 32'h00FF_0000});
    sb.push_back({32'h1080_0008, 32'h00FF_0000});
    sb.push_back({32'h1080_000C, 32'h00FF_0000});
    trigger();
    check("lat_ready_low", line_ready, 0);
    check("lat_setup_novalid", px_valid, 0);
    tick();
    check("lat_first_valid", px_valid, 1);
    wait_idle(c);
    check("h_cycles", c, 4);
    check("h_sb_empty", sb.size(), 0);

    // Degenerate line
    load(2, 5, 2, 5, 32'h0000_00AA);
    sb.push_back({32'h1080_5008, 32'h0000_00AA});
    trigger();
    wait_idle(c);
    check("deg_cycles", c, 2);
    check("deg_sb_empty", sb.size(), 0);

    // Steep line
    load(0, 0, 1, 3, 32'h0012_3456);
    sb.push_back({pa(0, 0), 32'h0012_3456});
    sb.push_back({pa(0, 1), 32'h0012_3456});
    sb.push_back({pa(1, 2), 32'h0012_3456});
    sb.push_back({pa(1, 3), 32'h0012_3456});
    trigger();
    wait_idle(c);
    check("steep_cycles", c, 5);
    check("steep_sb_empty", sb.size(), 0);

    // Reverse line
    load(3, 2, 0, 0, 32'hDEAD_BEEF);
    sb.push_back({pa(3, 2), 32'hDEAD_BEEF});
    sb.push_back({pa(2, 1), 32'hDEAD_BEEF});
    sb.push_back({pa(1, 1), 32'hDEAD_BEEF});
    sb.push_back({pa(0, 0), 32'hDEAD_BEEF});
    trigger();
    wait_idle(c);
    check("rev_cycles", c, 5);
    check("rev_sb_empty", sb.size(), 0);

    // Backpressure on the second pixel
    load(0, 0, 4, 0, 32'h0055_AA55);
    n = model_line(0, 0, 4, 0, 32'h0055_AA55);
    trigger();
    tick();
    tick();
    px_ready = 1'b0;
    repeat (5) tick();
    check("bp_addr", px_addr, pa(1, 0));
    check("bp_valid", px_valid, 1);
    px_ready = 1'b1;
    wait_idle(c);
    check("bp_sb_empty", sb.size(), 0);

    // Off-screen tail
    load(0, 766, 0, 769, 32'h0000_7777);
    sb.push_back({pa(0, 766), 32'h0000_7777});
    sb.push_back({pa(0, 767), 32'h0000_7777});
    trigger();
    wait_idle(c);
    check("off_cycles", c, 5);
    check("off_sb_empty", sb.size(), 0);

    // Trigger while busy is ignored; new x1 applies to the next line
    load(0, 0, 9, 0, 32'h0000_1111);
    n = model_line(0, 0, 9, 0, 32'h0000_1111);
    trigger();
    tick();
    tick();
    strobe(2, 32'd2);
    trigger();
    wait_idle(c);
    check("busy_sb_empty", sb.size(), 0);
    n = model_line(0, 0, 2, 0, 32'h0000_1111);
    trigger();
    wait_idle(c);
    check("newx1_cycles", c, 4);
    check("newx1_sb_empty", sb.size(), 0);

    // Reset during the third pixel of a 10-pixel line
    load(0, 1, 9, 1, 32'h0000_2222);
    n = model_line(0, 1, 9, 1, 32'h0000_2222);
    trigger();
    tick();
    tick();
    tick();
    check("mid_valid", px_valid, 1);
    check("mid_consumed", sb.size(), 8);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", px_valid, 0);
    check("mid_rst_ready", line_ready, 1);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("mid_rst_idle", line_ready, 1);
    // Shadow registers were cleared by reset: one black pixel at the origin
    sb.push_back({FB_BASE, 32'h0});
    trigger();
    wait_idle(c);
    check("rst_shadow_cycles", c, 2);
    check("rst_shadow_sb_empty", sb.size(), 0);

    // Random lines with random backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx0 = $urandom_range(0, 1023);
      ry0 = $urandom_range(0, 1023);
      rx1 = (i < 3) ? rx0 + $urandom_range(0, 40) - 20 : $urandom_range(0, 1023);
      ry1 = (i < 3) ? ry0 + $urandom_range(0, 40) - 20 : $urandom_range(0, 1023);
      if (rx1 < 0) rx1 = 0;
      if (rx1 > 1023) rx1 = 1023;
      if (ry1 < 0) ry1 = 0;
      if (ry1 > 1023) ry1 = 1023;
      load(rx0, ry0, rx1, ry1, $urandom);
      n = model_line(rx0, ry0, rx1, ry1, line_color);
      trigger();
      wait_idle(c);
      check("rnd_sb_empty", sb.size(), 0);
    end
    rnd_ready = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
